// File: rtl/spram_fifo_vr_if.sv
// rtl/spram_fifo_vr_if.sv - producer/consumer bundle for spram_fifo_vr
// Error-flag signals exist only when SPRAM_FIFO_ERR_FLAGS_EN is defined.
interface spram_fifo_vr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32
);
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  empty;
  logic                  rvalid;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
`ifdef SPRAM_FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output ren, wen, wdata,
`ifdef SPRAM_FIFO_ERR_FLAGS_EN
    input  overflow, underflow,
`endif
    input  rdata, empty, rvalid, full, count
  );

  modport slave (
    input  ren, wen, wdata,
`ifdef SPRAM_FIFO_ERR_FLAGS_EN
    output overflow, underflow,
`endif
    output rdata, empty, rvalid, full, count
  );
endinterface

// File: rtl/spram_fifo_vr.sv
// rtl/spram_fifo_vr.sv - single-port-RAM FIFO, write-priority arbitration, registered read data
// Define SPRAM_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module spram_fifo_vr #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  spram_fifo_vr_if.slave  bus
);
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  empty;
  logic                  full;
  logic                  wr_acc;
  logic                  rd_acc;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH_CNT);

  // The RAM has one port, so a write in the same cycle wins and the read is dropped.
  assign wr_acc = bus.wen & ~full;
  assign rd_acc = bus.ren & ~empty & ~wr_acc;
  assign addr   = wr_acc ? wptr : rptr;

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[addr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_acc;
      if (wr_acc) begin
        wptr  <= wptr + 1'b1;
        count <= count + 1'b1;
      end
      if (rd_acc) begin
        rdata <= mem[addr];
        rptr  <= rptr + 1'b1;
        count <= count - 1'b1;
      end
    end
  end

  assign bus.rdata  = rdata;
  assign bus.rvalid = rvalid;
  assign bus.empty  = empty;
  assign bus.full   = full;
  assign bus.count  = count;

`ifdef SPRAM_FIFO_ERR_FLAGS_EN
  logic overflow;
  logic underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.wen && full)  overflow  <= 1'b1;
      if (bus.ren && empty) underflow <= 1'b1;
    end
  end

  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
`endif
endmodule

// File: tb/tb_spram_fifo_vr.sv
// tb/tb_spram_fifo_vr.sv - scoreboard bench for spram_fifo_vr
// Read data is checked by a negedge monitor against a queue filled as reads are issued.
module tb_spram_fifo_vr;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  spram_fifo_vr_if #(.DATA_WIDTH(8), .FIFO_DEPTH(32)) bus ();

  spram_fifo_vr #(.DATA_WIDTH(8), .FIFO_DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wen = 1'b0;
    bus.ren = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: got rdata %0d expected no rvalid", bus.rdata);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (bus.rdata !== 8'(e)) begin
          errors++;
          $display("FAIL rdata_order: got %0d expected %0d", bus.rdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.wdata = '0;
    idle();
    tick();
    tick();
    check("reset_empty", int'(bus.empty), 1);
    check("reset_full", int'(bus.full), 0);
    check("reset_count", int'(bus.count), 0);
    check("reset_rvalid", int'(bus.rvalid), 0);
    check("reset_rdata", int'(bus.rdata), 0);
`ifdef SPRAM_FIFO_ERR_FLAGS_EN
    check("reset_overflow", int'(bus.overflow), 0);
    check("reset_underflow", int'(bus.underflow), 0);
`endif
    rst = 1'b0;

    for (int v = 10; v <= 12; v++) begin
      bus.wen = 1'b1;
      bus.wdata = 8'(v);
      tick();
    end
    idle();
    check("three_writes_count", int'(bus.count), 3);
    check("three_writes_empty", int'(bus.empty), 0);

    bus.ren = 1'b1;
    exp_q.push_back(10);
    tick();
    idle();
    check("first_read_rvalid", int'(bus.rvalid), 1);
    check("first_read_rdata", int'(bus.rdata), 10);
    check("first_read_count", int'(bus.count), 2);

    // Write wins the collision; the read is dropped with no rvalid.
    bus.wen = 1'b1;
    bus.wdata = 8'd13;
    bus.ren = 1'b1;
    tick();
    idle();
    check("collision_count", int'(bus.count), 3);
    check("collision_rvalid", int'(bus.rvalid), 0);

    exp_q.push_back(11);
    exp_q.push_back(12);
    exp_q.push_back(13);
    bus.ren = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    idle();
    check("over_read_empty", int'(bus.empty), 1);
    check("over_read_rvalid", int'(bus.rvalid), 0);
    check("over_read_count", int'(bus.count), 0);

    for (int v = 0; v < 32; v++) begin
      bus.wen = 1'b1;
      bus.wdata = 8'(v);
      tick();
    end
    idle();
    check("fill_full", int'(bus.full), 1);
    check("fill_count", int'(bus.count), 32);

    bus.wen = 1'b1;
    bus.wdata = 8'd99;
    tick();
    idle();
    check("write_when_full_count", int'(bus.count), 32);

    bus.wen = 1'b1;
    bus.wdata = 8'd77;
    bus.ren = 1'b1;
    exp_q.push_back(0);
    tick();
    idle();
    check("full_collision_count", int'(bus.count), 31);
    check("full_collision_rvalid", int'(bus.rvalid), 1);
    check("full_collision_rdata", int'(bus.rdata), 0);
    check("full_collision_full", int'(bus.full), 0);

    bus.ren = 1'b1;
    for (int v = 1; v < 32; v++) begin
      exp_q.push_back(v);
      tick();
    end
    idle();
    tick();
    check("drain_empty", int'(bus.empty), 1);
    check("drain_count", int'(bus.count), 0);

    // Two batches of 20 carry both pointers across the wrap point.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 20; i++) begin
        bus.wen = 1'b1;
        bus.wdata = 8'(100 + b * 20 + i);
        tick();
      end
      idle();
      check("wrap_batch_count", int'(bus.count), 20);
      bus.ren = 1'b1;
      for (int i = 0; i < 20; i++) begin
        exp_q.push_back(100 + b * 20 + i);
        tick();
      end
      idle();
      tick();
      check("wrap_batch_empty", int'(bus.empty), 1);
    end

    bus.ren = 1'b1;
    tick();
    idle();
    check("empty_read_rvalid", int'(bus.rvalid), 0);
`ifdef SPRAM_FIFO_ERR_FLAGS_EN
    tick();
    tick();
    check("underflow_sticky", int'(bus.underflow), 1);
    check("overflow_sticky", int'(bus.overflow), 1);
`endif

    for (int v = 0; v < 5; v++) begin
      bus.wen = 1'b1;
      bus.wdata = 8'(200 + v);
      tick();
    end
    idle();
    check("pre_reset_count", int'(bus.count), 5);
    bus.ren = 1'b1;
    rst = 1'b1;
    tick();
    idle();
    rst = 1'b0;
    check("midop_reset_count", int'(bus.count), 0);
    check("midop_reset_rvalid", int'(bus.rvalid), 0);
    check("midop_reset_empty", int'(bus.empty), 1);
    check("midop_reset_rdata", int'(bus.rdata), 0);
`ifdef SPRAM_FIFO_ERR_FLAGS_EN
    check("midop_reset_underflow", int'(bus.underflow), 0);
    check("midop_reset_overflow", int'(bus.overflow), 0);
`endif

    bus.wen = 1'b1;
    bus.wdata = 8'd55;
    tick();
    idle();
    bus.ren = 1'b1;
    exp_q.push_back(55);
    tick();
    idle();
    check("post_reset_rdata", int'(bus.rdata), 55);
    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
